// File: rtl/fp_addsub_rule_monitor.sv
// In-order checker for an FP add/sub unit: queues issued operands, pairs them with
// returned results and flags IEEE-754 special-case rule violations.
module fp_addsub_rule_monitor #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_op,
    input  logic             res_valid,
    input  logic [W-1:0]     res_data,
    output logic             chk_valid,
    output logic [5:0]       chk_hit,
    output logic [5:0]       chk_err,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sticky_fail,
    output logic             overrun,
    output logic             orphan,
    output logic [OCC_W-1:0] pending
);

    logic [W-1:0]     mem_a [DEPTH];
    logic [W-1:0]     mem_b [DEPTH];
    logic             mem_op [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] count;

    logic empty, full, do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = res_valid && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = in_valid && (!full || do_pop);
    assign pending = count;

    logic [W-1:0] a_h, b_h;
    logic         op_h;
    assign a_h  = mem_a[rd_ptr];
    assign b_h  = mem_b[rd_ptr];
    assign op_h = mem_op[rd_ptr];

    logic sa, sb, sr;
    logic a_inf, a_nan, a_fin, a_nz;
    logic b_inf, b_nan, b_fin, b_nz;
    logic r_inf, r_nan;
    logic inf_sign;
    logic [5:0] hit, err;

    always_comb begin
        sa    = a_h[W-1];
        sb    = b_h[W-1] ^ op_h;
        sr    = res_data[W-1];
        a_inf = (&a_h[W-2 -: EXP_W]) && ~|a_h[MAN_W-1:0];
        a_nan = (&a_h[W-2 -: EXP_W]) &&  |a_h[MAN_W-1:0];
        a_fin = ~&a_h[W-2 -: EXP_W];
        a_nz  = |a_h[W-2:0];
        b_inf = (&b_h[W-2 -: EXP_W]) && ~|b_h[MAN_W-1:0];
        b_nan = (&b_h[W-2 -: EXP_W]) &&  |b_h[MAN_W-1:0];
        b_fin = ~&b_h[W-2 -: EXP_W];
        b_nz  = |b_h[W-2:0];
        r_inf = (&res_data[W-2 -: EXP_W]) && ~|res_data[MAN_W-1:0];
        r_nan = (&res_data[W-2 -: EXP_W]) &&  |res_data[MAN_W-1:0];
        inf_sign = a_inf ? sa : sb;

        hit    = '0;
        err    = '0;
        hit[0] = a_inf && b_inf && (sa == sb);
        hit[1] = a_inf && b_inf && (sa != sb);
        hit[2] = a_nan || b_nan;
        hit[3] = a_fin && b_fin && (a_h[W-2:0] == b_h[W-2:0]) && (sa != sb);
        hit[4] = a_fin && b_fin && a_nz && b_nz && (sa == sb);
        hit[5] = (a_inf && b_fin) || (b_inf && a_fin);

        err[0] = hit[0] && !(r_inf && (sr == sa));
        err[1] = hit[1] && !r_nan;
        err[2] = hit[2] && !r_nan;
        err[3] = hit[3] && (res_data != '0);
        err[4] = hit[4] && (sr != sa);
        err[5] = hit[5] && !(r_inf && (sr == inf_sign));
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            chk_valid   <= 1'b0;
            chk_hit     <= '0;
            chk_err     <= '0;
            chk_cnt     <= '0;
            err_cnt     <= '0;
            sticky_fail <= 1'b0;
            overrun     <= 1'b0;
            orphan      <= 1'b0;
        end else begin
            chk_valid <= do_pop;
            chk_hit   <= do_pop ? hit : '0;
            chk_err   <= do_pop ? err : '0;

            if (do_pop) begin
                if (chk_cnt != '1) chk_cnt <= chk_cnt + CNT_W'(1);
                if (|err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end

            if (in_valid && !do_push) overrun <= 1'b1;
            if (res_valid && empty)   orphan  <= 1'b1;
            if ((do_pop && |err) || (in_valid && !do_push) || (res_valid && empty))
                sticky_fail <= 1'b1;

            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            unique case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_rule_monitor.sv
// Bench for fp_addsub_rule_monitor: table vectors, directed FIFO/counter sequences and
// random traffic, all compared every cycle against a queue-based reference model.
module tb_fp_addsub_rule_monitor;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_op, res_valid;
    logic [31:0] in_a, in_b, res_data;
    logic        chk_valid, sticky_fail, overrun, orphan;
    logic [5:0]  chk_hit, chk_err;
    logic [CW-1:0] chk_cnt, err_cnt;
    logic [2:0]  pending;

    fp_addsub_rule_monitor #(.EXP_W(8), .MAN_W(23), .DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .res_valid(res_valid), .res_data(res_data),
        .chk_valid(chk_valid), .chk_hit(chk_hit), .chk_err(chk_err),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt), .sticky_fail(sticky_fail),
        .overrun(overrun), .orphan(orphan), .pending(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } tx_t;

    localparam int K_ZERO = 0, K_FIN = 1, K_INF = 2, K_NAN = 3;

    function automatic int kind_of(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? K_INF : K_NAN;
        return (x[30:0] == 0) ? K_ZERO : K_FIN;
    endfunction

    function automatic void ref_rules(input tx_t t, input logic [31:0] r,
                                      output logic [5:0] hit, output logic [5:0] err);
        int  ka, kb, kr;
        logic sa, sb, sr, want;
        ka = kind_of(t.a); kb = kind_of(t.b); kr = kind_of(r);
        sa = t.a[31]; sb = t.b[31] ^ t.op; sr = r[31];
        hit = '0; err = '0;
        if (ka == K_NAN || kb == K_NAN) begin
            hit[2] = 1'b1; err[2] = (kr != K_NAN);
        end else if (ka == K_INF && kb == K_INF) begin
            if (sa == sb) begin hit[0] = 1'b1; err[0] = !(kr == K_INF && sr == sa); end
            else          begin hit[1] = 1'b1; err[1] = (kr != K_NAN); end
        end else if (ka == K_INF || kb == K_INF) begin
            want = (ka == K_INF) ? sa : sb;
            hit[5] = 1'b1; err[5] = !(kr == K_INF && sr == want);
        end else begin
            if (sa != sb && t.a[30:0] == t.b[30:0]) begin hit[3] = 1'b1; err[3] = (r != 0); end
            if (sa == sb && ka == K_FIN && kb == K_FIN) begin hit[4] = 1'b1; err[4] = (sr != sa); end
        end
    endfunction

    tx_t        m_q[$];
    logic       m_valid, m_sticky, m_over, m_orph;
    logic [5:0] m_hit, m_err;
    int         m_cnt, m_ecnt;
    int         max_cnt = (1 << CW) - 1;

    task automatic model_reset();
        m_q.delete();
        m_valid = 0; m_hit = 0; m_err = 0; m_cnt = 0; m_ecnt = 0;
        m_sticky = 0; m_over = 0; m_orph = 0;
    endtask

    task automatic model_step();
        tx_t t;
        if (!rst_n || clear) begin
            model_reset();
            return;
        end
        m_valid = 0; m_hit = 0; m_err = 0;
        if (res_valid) begin
            if (m_q.size() == 0) begin
                m_orph = 1; m_sticky = 1;
            end else begin
                t = m_q.pop_front();
                ref_rules(t, res_data, m_hit, m_err);
                m_valid = 1;
                if (m_cnt < max_cnt) m_cnt++;
                if (m_err != 0) begin
                    if (m_ecnt < max_cnt) m_ecnt++;
                    m_sticky = 1;
                end
            end
        end
        if (in_valid) begin
            if (m_q.size() < 4) begin
                t.a = in_a; t.b = in_b; t.op = in_op;
                m_q.push_back(t);
            end else begin
                m_over = 1; m_sticky = 1;
            end
        end
    endtask

    task automatic compare();
        check("chk_valid", chk_valid, m_valid);
        if (m_valid) begin
            check("chk_hit", chk_hit, m_hit);
            check("chk_err", chk_err, m_err);
        end
        check("chk_cnt", chk_cnt, m_cnt);
        check("err_cnt", err_cnt, m_ecnt);
        check("sticky_fail", sticky_fail, m_sticky);
        check("overrun", overrun, m_over);
        check("orphan", orphan, m_orph);
        check("pending", pending, m_q.size());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic rv, input logic [31:0] r);
        in_valid = iv; in_a = a; in_b = b; in_op = op;
        res_valid = rv; res_data = r;
        tick();
        in_valid = 0; res_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // ---------------- random operand generator ----------------
    function automatic logic [31:0] rnd_val();
        logic [31:0] s;
        s = {$urandom_range(0, 1) == 1, 31'h0};
        case ($urandom_range(0, 7))
            0: return s;
            1: return s | 32'h7F80_0000;
            2: return s | 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
            3: return s | 32'h3F80_0000;
            4: return s | {1'b0, 8'($urandom_range(0, 254)), 23'($urandom())};
            default: return $urandom();
        endcase
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [5:0]  hit;
        logic [5:0]  err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 6'b000001, 6'b000000};
        vecs[1]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F7FFFFF, 6'b000001, 6'b000001};
        vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 6'b000010, 6'b000000};
        vecs[3]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h3F800000, 6'b000100, 6'b000100};
        vecs[4]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h80000000, 6'b001000, 6'b001000};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 6'b001000, 6'b000000};
        vecs[6]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 6'b010000, 6'b000000};
        vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000, 6'b010000, 6'b010000};
        vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 6'b100000, 6'b000000};
        vecs[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'h7F800000, 6'b100000, 6'b100000};
        vecs[10] = '{32'hBF800000, 32'hBF800000, 1'b0, 32'h00000000, 6'b010000, 6'b010000};
        vecs[11] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7F800000, 6'b000010, 6'b000010};
        vecs[12] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 6'b001000, 6'b000000};

        rst_n = 0; clear = 0; in_valid = 0; res_valid = 0;
        in_a = 0; in_b = 0; in_op = 0; res_data = 0;
        model_reset();
        tick(); tick();
        rst_n = 1;
        check("rst_pending", pending, 0);
        check("rst_chk_cnt", chk_cnt, 0);
        check("rst_sticky", sticky_fail, 0);

        // table vectors: issue, return one cycle later, check registered outcome
        for (int i = 0; i < 13; i++) begin
            cyc(1, vecs[i].a, vecs[i].b, vecs[i].op, 0, 0);
            cyc(0, 0, 0, 0, 1, vecs[i].res);
            check($sformatf("tbl%0d_valid", i), chk_valid, 1);
            check($sformatf("tbl%0d_hit", i), chk_hit, vecs[i].hit);
            check($sformatf("tbl%0d_err", i), chk_err, vecs[i].err);
            if (i == 1) begin
                check("tbl_err_cnt1", err_cnt, 1);
                check("tbl_sticky1", sticky_fail, 1);
            end
            cyc(0, 0, 0, 0, 0, 0);
            check($sformatf("tbl%0d_pulse", i), chk_valid, 0);
        end

        // FIFO full / overrun / drain / orphan
        do_clear();
        for (int i = 0; i < 5; i++) cyc(1, 32'h3F800000, 32'h40000000, 0, 0, 0);
        check("ovr_pending", pending, 4);
        check("ovr_flag", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 32'h40400000);
            check("drain_valid", chk_valid, 1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        check("drain_idle", chk_valid, 0);
        cyc(0, 0, 0, 0, 1, 32'h40400000);
        check("orphan_flag", orphan, 1);
        check("orphan_novalid", chk_valid, 0);

        // full FIFO with simultaneous push and pop: push must land
        do_clear();
        for (int i = 0; i < 4; i++) cyc(1, 32'h3F800000, 32'h3F800000, 0, 0, 0);
        cyc(1, 32'h7F800000, 32'h7F800000, 0, 1, 32'h40000000);
        check("fullpp_pending", pending, 4);
        check("fullpp_overrun", overrun, 0);
        // empty FIFO with simultaneous push and result: orphan, push kept
        do_clear();
        cyc(1, 32'h3F800000, 32'h3F800000, 0, 1, 32'h40000000);
        check("emptypp_orphan", orphan, 1);
        check("emptypp_pending", pending, 1);
        check("emptypp_novalid", chk_valid, 0);

        // counter saturation
        do_clear();
        for (int i = 0; i < 17; i++) begin
            cyc(1, 32'h7F800000, 32'h7F800000, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 32'h7F7FFFFF);
        end
        check("sat_err_cnt", err_cnt, 15);
        check("sat_chk_cnt", chk_cnt, 15);
        do_clear();
        check("clr_err_cnt", err_cnt, 0);
        check("clr_chk_cnt", chk_cnt, 0);
        check("clr_sticky", sticky_fail, 0);

        // clear ignores traffic in its own cycle
        in_valid = 1; in_a = 32'h3F800000; in_b = 32'h3F800000; res_valid = 1;
        do_clear();
        in_valid = 0; res_valid = 0;
        check("clr_ignore_pending", pending, 0);
        check("clr_ignore_orphan", orphan, 0);

        // reset mid-operation discards pending transactions
        cyc(1, 32'h3F800000, 32'h3F800000, 0, 0, 0);
        cyc(1, 32'h3F800000, 32'h3F800000, 0, 0, 0);
        check("pre_rst_pending", pending, 2);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("rst_mid_pending", pending, 0);
        cyc(0, 0, 0, 0, 1, 32'h0);
        check("rst_mid_orphan", orphan, 1);
        check("rst_mid_novalid", chk_valid, 0);

        // random traffic against the reference model
        do_clear();
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a, b;
            a = rnd_val();
            b = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, a[30:0]} : rnd_val();
            clear     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a = a; in_b = b; in_op = $urandom_range(0, 1) == 1;
            res_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            res_data  = ($urandom_range(0, 4) == 0) ? 32'h0 : rnd_val();
            tick();
            clear = 0; in_valid = 0; res_valid = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_addsub_rule_monitor.md
Name: fp_addsub_rule_monitor

Overview:
- Synthesizable, parametrised checker for the FP add/sub datapath.
- Queues operand/operation transactions at DUT issue and pairs each with the DUT's result when it returns, in order.
- Checks IEEE-754 special-case rules (infinities, NaN, exact cancellation, sign) and reports per-rule hit/error vectors, saturating counters and a sticky fail flag.
- Used in simulation and on FPGA debug builds. It has no floating-point reference model; general arithmetic correctness is out of scope.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, mantissa width. Word width W = 1+EXP_W+MAN_W.
- DEPTH, 4, pending-transaction FIFO depth (power of 2, >=2).
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear of counters, sticky flags and FIFO.
- in_valid  in  1  DUT accepts an operation this cycle.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- in_op  in  1  0 = ADD, 1 = SUB.
- res_valid  in  1  DUT result valid this cycle.
- res_data  in  W  DUT result.
- chk_valid  out  1  check outcome valid (one-cycle pulse).
- chk_hit  out  6  rules applicable to the checked transaction.
- chk_err  out  6  rules violated (always a subset of chk_hit).
- chk_cnt  out  CNT_W  completed checks, saturating.
- err_cnt  out  CNT_W  checks with any chk_err bit set, saturating.
- sticky_fail  out  1  set on any rule error, overrun or orphan.
- overrun  out  1  sticky: push attempted while FIFO full.
- orphan  out  1  sticky: result arrived with FIFO empty.
- pending  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0, FIFO empty, all sticky flags cleared. Reset mid-operation discards pending transactions.
- clear: same effect as reset except it is not a reset. When rst_n and clear are both asserted, reset applies. Any in_valid or res_valid in the clear cycle is ignored.
- Push: in_valid and not full stores {a, b, op}. in_valid while full drops the transaction and sets overrun.
- Pop: res_valid and not empty pops the head. res_valid while empty sets orphan; no check and no chk_valid.
- Simultaneous push and pop: both occur. When full, the pop frees the slot and the push succeeds. When empty, orphan is set and the push proceeds; there is no bypass. The DUT latency is >=1 cycle.
- Check (on pop) is registered: chk_valid, chk_hit and chk_err update exactly 1 cycle after res_valid. chk_cnt increments on every check; err_cnt increments if chk_err != 0. Both counters hold at all-ones.
- Definitions:
  - Effective b sign sb' = b.sign ^ op.
  - INF = exponent all-ones, mantissa 0.
  - NaN = exponent all-ones, mantissa != 0.
  - Finite = exponent not all-ones.
- Rules (bit index, at most one of 0/1/2/5 hits):
  - 0 INF_SAME: a and b both INF, a.sign == sb' -> result is INF with sign a.sign.
  - 1 INF_CANCEL: a and b both INF, a.sign != sb' -> result is NaN.
  - 2 NAN_PROP: a or b is NaN -> result is NaN.
  - 3 CANCEL: both finite, a[W-2:0] == b[W-2:0], a.sign != sb' -> result == all-zeros (+0).
  - 4 SIGN: both finite, both magnitudes nonzero, a.sign == sb' -> result.sign == a.sign.
  - 5 INF_ONE: exactly one operand INF, the other finite -> result is that infinity, with sign a.sign if a is INF, else sb'.
- sticky_fail = OR of all error conditions seen since reset/clear.
- pending reflects post-edge occupancy.

Test Plan:
- a = b = 0x7F800000, op = 0, res = 0x7F800000 -> chk_hit = 000001, chk_err = 0. Repeat with res = 0x7F7FFFFF -> chk_err = 000001, err_cnt = 1, sticky_fail = 1.
- a = b = 0x7F800000, op = 1, res = 0x7FC00000 -> hit bit 1, no error. a = 0x7FC00000, b = 0x3F800000, op = 0, res = 0x3F800000 -> chk_err bit 2.
- a = b = 0x3F800000, op = 1, res = 0x80000000 -> chk_hit = 001000, chk_err = 001000. Same stimulus with res = 0x00000000 -> no error.
- DEPTH = 4: 5 pushes with no pops -> pending = 4, overrun = 1. Then 4 pops -> 4 chk_valid pulses, 1 cycle after each res_valid. 5th res_valid -> orphan = 1, no chk_valid.
- CNT_W = 4: 17 failing checks -> err_cnt = 15 and chk_cnt = 15 (both held). clear -> all counters and flags 0.
- 2 transactions pending, rst_n low for 1 cycle -> pending = 0. Next res_valid -> orphan = 1.
